// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle for the RV32M multiply/divide unit.
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high; the sender holds valid and its payload stable
// until that edge, and ready may change freely while valid is low.
// dbg_state mirrors the unit's FSM state register for observation.
interface riscv_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output in_valid, funct3, op_a, op_b, flush, out_ready,
        input  in_ready, out_valid, result, busy, dbg_state
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, flush, out_ready,
        output in_ready, out_valid, result, busy, dbg_state
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Shift-add multiply and restoring divide on operand magnitudes, one radix-2
// step per cycle, sign correction on the final CALC->DONE edge.
// Optional build macro RISCV_MULDIV_EARLY_OUT_EN: special cases (divide by zero,
// signed overflow, a zero operand) skip CALC and complete one cycle after accept.
module riscv_muldiv_unit #(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input logic                clk,
    input logic                rst_n,
    riscv_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = '0;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [2:0]              op_q, op_d;
    logic                    neg_res_q, neg_res_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    special_q, special_d;
    logic [DATA_WIDTH-1:0]   spec_res_q, spec_res_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    // Request decode: operand signedness, magnitudes and special-case result
    logic                    a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [DATA_WIDTH-1:0]   a_mag_in, b_mag_in;
    logic                    special_in;
    logic [DATA_WIDTH-1:0]   spec_res_in;

    always_comb begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        if (bus.funct3[2]) begin
            // DIV and REM are signed, DIVU and REMU are not
            a_signed_in = ~bus.funct3[0];
            b_signed_in = ~bus.funct3[0];
        end else begin
            // MUL/MULH: both signed, MULHSU: only rs1, MULHU: neither
            a_signed_in = (bus.funct3[1:0] != 2'b11);
            b_signed_in = ~bus.funct3[1];
        end
        a_neg_in = a_signed_in & bus.op_a[DATA_WIDTH-1];
        b_neg_in = b_signed_in & bus.op_b[DATA_WIDTH-1];
        a_mag_in = a_neg_in ? (ZERO_W - bus.op_a) : bus.op_a;
        b_mag_in = b_neg_in ? (ZERO_W - bus.op_b) : bus.op_b;

        special_in  = 1'b0;
        spec_res_in = '0;
        if (bus.funct3[2] && (bus.op_b == ZERO_W)) begin
            special_in  = 1'b1;
            spec_res_in = bus.funct3[1] ? bus.op_a : ALL_ONES;
        end else if (bus.funct3[2] && !bus.funct3[0] &&
                     (bus.op_a == MOST_NEG) && (bus.op_b == ALL_ONES)) begin
            special_in  = 1'b1;
            spec_res_in = bus.funct3[1] ? ZERO_W : bus.op_a;
        end else if ((bus.op_a == ZERO_W) || (bus.op_b == ZERO_W)) begin
            special_in  = 1'b1;
            spec_res_in = '0;
        end
    end

    // One radix-2 step: shift-add for multiply, restore-compare for divide
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH-1:0]   rem_sub;
    logic                    rem_ge;
    logic [2*DATA_WIDTH-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    (acc_q[0] ? {1'b0, b_mag_q} : {(DATA_WIDTH+1){1'b0}});
        rem_shift = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
        rem_ge    = (rem_shift >= {1'b0, b_mag_q});
        // Remainder stays below the divisor, so the low bits of the difference are exact
        rem_sub   = rem_shift[DATA_WIDTH-1:0] - b_mag_q;
        if (op_q[2]) begin
            step_acc = {(rem_ge ? rem_sub : rem_shift[DATA_WIDTH-1:0]),
                        acc_q[DATA_WIDTH-2:0], rem_ge};
        end else begin
            step_acc = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        end
    end

    // Sign-corrected final result selected by the latched opcode
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fin_res;

    always_comb begin
        prod_fix = neg_res_q ? ({(2*DATA_WIDTH){1'b0}} - acc_q) : acc_q;
        quo_fix  = neg_res_q ? (ZERO_W - acc_q[DATA_WIDTH-1:0]) : acc_q[DATA_WIDTH-1:0];
        rem_fix  = neg_rem_q ? (ZERO_W - acc_q[2*DATA_WIDTH-1:DATA_WIDTH])
                             : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (op_q[2]) begin
            fin_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fin_res = (op_q[1:0] == 2'b00) ? prod_fix[DATA_WIDTH-1:0]
                                           : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_mag_d    = b_mag_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                // flush wins over a same-cycle request
                if (bus.in_valid && !bus.flush) begin
                    op_d       = bus.funct3;
                    acc_d      = {ZERO_W, a_mag_in};
                    b_mag_d    = b_mag_in;
                    neg_res_d  = a_neg_in ^ b_neg_in;
                    neg_rem_d  = a_neg_in;
                    special_d  = special_in;
                    spec_res_d = spec_res_in;
                    cnt_d      = CNT_W'(DATA_WIDTH);
                    state_d    = CALC;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
                    if (special_in) begin
                        result_d = spec_res_in;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Extra edge after the last step applies the sign fix
                    result_d = special_q ? spec_res_q : fin_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.flush || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_mag_q    <= '0;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_mag_q    <= b_mag_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed testbench for riscv_muldiv_unit (DATA_WIDTH = 32).
module tb_riscv_muldiv_unit;

    localparam int W = 32;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    logic clk;
    logic rst_n;

    riscv_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

    riscv_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver: issue one request, wait for the result, check latency and value
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
        int lat;
        logic [W-1:0] e;
        check_val({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        bus.funct3   = f3;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.funct3   = 3'($urandom_range(0, 7));
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        check_val({tag, "_latency"}, W'(lat), W'(exp_lat));
        e = exp_q.pop_front();
        check_val(tag, bus.result, e);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_idle_after"}, W'(bus.busy), W'(0));
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.funct3   = f3;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held;
        logic         seen;
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'b000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  W'(bus.in_ready),  W'(1));
        check_val("rst_out_valid", W'(bus.out_valid), W'(0));
        check_val("rst_result",    bus.result,        W'(0));
        check_val("rst_busy",      W'(bus.busy),      W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // multiply
        run_op("mul_7_m3",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
        run_op("mulhu_ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
        run_op("mulh_ff",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FULL_LAT);
        run_op("mulhsu_m1_2",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
        run_op("mul_big",      3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, FULL_LAT);
        // divide
        run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, FULL_LAT);
        run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
        run_op("divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        FULL_LAT);
        run_op("remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         FULL_LAT);
        run_op("div_7_m2",     3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
        run_op("rem_7_m2",     3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, FULL_LAT);
        // special cases
        run_op("div_by_0",     3'b100, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("rem_by_0",     3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, SPEC_LAT);
        run_op("divu_by_0",    3'b101, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("div_neg_by_0", 3'b100, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);

        // hold result with out_ready low
        start_op(3'b101, 32'd1000, 32'd10);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.out_valid;
        end
        check_val("hold_out_valid", W'(seen), W'(1));
        held = bus.result;
        check_val("hold_value", held, 32'd100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.result !== held || !bus.out_valid || bus.in_ready)
                check_val("hold_stable", bus.result, held);
        end
        check_val("hold_in_ready",  W'(bus.in_ready),  W'(0));
        check_val("hold_out_valid2", W'(bus.out_valid), W'(1));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("hold_release_ready", W'(bus.in_ready), W'(1));
        start_op(3'b000, 32'd3, 32'd4);
        check_val("hold_new_accept", W'(bus.busy), W'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;

        // flush mid-CALC with a concurrent request
        start_op(3'b000, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd9;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("flush_state", W'(bus.dbg_state), W'(0));
        check_val("flush_in_ready", W'(bus.in_ready), W'(1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check_val("flush_no_out", W'(seen), W'(0));

        // flush in DONE drops the result
        start_op(3'b101, 32'd50, 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.out_valid;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_val("flush_done", W'(bus.out_valid), W'(0));

        // async reset mid-CALC
        start_op(3'b000, 32'd11, 32'd13);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", W'(bus.out_valid), W'(0));
        check_val("arst_in_ready",  W'(bus.in_ready),  W'(1));
        check_val("arst_busy",      W'(bus.busy),      W'(0));
        check_val("arst_result",    bus.result,        W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst_mul", 3'b000, 32'd11, 32'd13, 32'd143, FULL_LAT);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
